fpadd_seq_ctrl: RTL and testbench
=================================

// Module: fpadd_seq_ctrl
// PURPOSE
//  Sequencer for the FP32 adder mantissa datapath. Drives ldm/shrm/shlm/cy of three mant registers:
//  operand A, operand B and result R. Handles the start/done handshake, exponent compare and
//  alignment shift count, post-add carry correction, left-normalisation and result exponent.
//  Sits between the top-level adder control and the mant instances.
// PARAMETERS
//  EXP_W     8   exponent width
//  MANT_W    24  mantissa width, hidden bit included
//  CNT_W     5   alignment/normalise counter width
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  reset      in   1      asynchronous, active-low; 0 forces reset state immediately
//  start      in   1      begin operation; sampled only in IDLE
//  exp_a      in   EXP_W  biased exponent of A; sampled when start is accepted
//  exp_b      in   EXP_W  biased exponent of B; sampled when start is accepted
//  add_cy     in   1      carry out of mantissa adder; valid in ADD
//  res_msb    in   1      R out_mant[MANT_W-1]
//  res_zero   in   1      R out_mant == 0
//  ldm_a      out  1      load A register
//  shrm_a     out  1      shift A right
//  ldm_b      out  1      load B register
//  shrm_b     out  1      shift B right
//  ldm_r      out  1      load R with adder sum
//  shrm_r     out  1      shift R right
//  shlm_r     out  1      shift R left
//  shr_cy     out  1      cy into the register being shifted right
//  exp_out    out  EXP_W  result exponent; valid while done=1
//  busy       out  1      1 in every state except IDLE
//  done       out  1      one-cycle pulse in DONE
//  ovf        out  1      exponent overflow; valid with done
// BEHAVIOUR
//  Reset (reset=0): state=IDLE; every output 0; exp_out=0; counters and captured exponents 0.
//  Reset mid-operation: same, asynchronously; the operation is abandoned and done is never pulsed.
//  Control encoding: all outputs registered (Moore). Per register, at most one of ldm/shrm/shlm is 1
//  in a cycle. shr_cy=0 except in NORM carry correction.
//  IDLE:  if start=1, capture exp_a/exp_b and go to LOAD. start while busy=1 is ignored.
//  LOAD:  ldm_a=ldm_b=1.
//         d = |exp_a-exp_b|, computed EXP_W+1 wide.
//         cnt = min(d,25); counts above 24 flush the mantissa to 0.
//         exp_r = max(exp_a,exp_b).
//         The smaller-exponent operand is marked for shifting; on a tie nothing is shifted.
//         Next state: ALIGN if cnt!=0, else ADD.
//  ALIGN: shrm of the smaller register (A if exp_a<exp_b, else B) = 1, with shr_cy=0.
//         cnt decrements each cycle. Exactly cnt shift cycles are issued, then go to ADD.
//  ADD:   ldm_r=1; add_cy is registered into cy_q. Go to NORM.
//  NORM:  evaluated in priority order:
//         cy_q=1     -> shrm_r=1, shr_cy=1, exp_r+1, clear cy_q, go to DONE.
//                       If exp_r was 254: ovf=1, exp_r=255.
//         res_zero=1 -> exp_r=0, go to DONE.
//         res_msb=0 and exp_r>1 -> shlm_r=1, exp_r-1, stay in NORM.
//         res_msb=0 and exp_r<=1 -> exp_r=0 (flush), go to DONE.
//         else (msb=1) -> go to DONE.
//         At most 23 left shifts, guaranteed by the msb check.
//  DONE:  done=1, exp_out=exp_r, ovf held. Next cycle go to IDLE; done, ovf and busy drop to 0.
//         start in the DONE cycle is ignored.
//  Latency: start accept -> done = 3 + cnt + nshift_norm + 1 cycles.
//  Minimum is 4, with equal exponents and a normalised sum.
//  exp_in=255 (Inf/NaN) is not special-cased here; the top level bypasses it.
// STRUCTURE
//  Shared include fpadd_pkg.vh: state codes S_IDLE..S_DONE (3-bit), EXP_MAX=255,
//  EXP_OVF_LIM=254, MAX_ALIGN=25.
//  One sub-module, fpadd_exp_unit (combinational):
//   - inputs exp_a, exp_b
//   - outputs diff_sat (CNT_W), a_lt_b, exp_max
//  FSM and exp_r inc/dec stay in this module.
// TESTING
//  1 exp_a=exp_b=127, add_cy=0, res_msb=1 -> no shrm, done 4 cycles after start, exp_out=127, ovf=0.
//  2 exp_a=130, exp_b=127 -> shrm_b=1 for exactly 3 consecutive cycles, shrm_a never 1, exp_out=130.
//  3 exp_a=100, exp_b=160 -> shrm_a=1 for 25 cycles (saturated), exp_out=160.
//  4 exp 127/127, add_cy=1 -> one cycle shrm_r=1 with shr_cy=1, exp_out=128.
//    Same with exp 254/254 -> ovf=1, exp_out=255.
//  5 exp 127/127, res_msb=0 for 3 NORM cycles then 1 -> shlm_r=1 for 3 cycles, exp_out=124.
//    res_zero=1 -> exp_out=0.
//  6 reset=0 during ALIGN -> all outputs 0 the same cycle, no done pulse.
//    start pulsed while busy -> ignored, no second done.

Source files
------------

// File: rtl/fpadd_pkg.sv
// Shared widths, limits and FSM state codes for the FP32 adder sequencer.
package fpadd_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 24;
  localparam int unsigned CNT_W  = 5;

  // Shifting by MANT_W+1 or more clears the mantissa, so alignment saturates here
  localparam int unsigned MAX_ALIGN = MANT_W + 1;

  localparam logic [EXP_W-1:0] EXP_MAX     = EXP_W'(255);
  localparam logic [EXP_W-1:0] EXP_OVF_LIM = EXP_W'(254);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ALIGN = 3'd2,
    S_ADD   = 3'd3,
    S_NORM  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/fpadd_exp_unit.sv
// Exponent compare: saturated alignment distance, operand ordering and larger exponent.
module fpadd_exp_unit
  import fpadd_pkg::*;
(
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  output logic [CNT_W-1:0] diff_sat,
  output logic             a_lt_b,
  output logic [EXP_W-1:0] exp_max
);

  localparam int unsigned DW = EXP_W + 1;

  logic [DW-1:0] abs_diff;

  always_comb begin
    a_lt_b   = (exp_a < exp_b);
    abs_diff = a_lt_b ? (DW'(exp_b) - DW'(exp_a)) : (DW'(exp_a) - DW'(exp_b));
    exp_max  = a_lt_b ? exp_b : exp_a;
    diff_sat = (abs_diff > DW'(MAX_ALIGN)) ? CNT_W'(MAX_ALIGN) : CNT_W'(abs_diff);
  end

endmodule

// File: rtl/fpadd_seq_ctrl.sv
// Sequencer for the FP32 adder mantissa datapath: align, add, carry-correct, normalise.
module fpadd_seq_ctrl
  import fpadd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic             add_cy,
  input  logic             res_msb,
  input  logic             res_zero,
  output logic             ldm_a,
  output logic             shrm_a,
  output logic             ldm_b,
  output logic             shrm_b,
  output logic             ldm_r,
  output logic             shrm_r,
  output logic             shlm_r,
  output logic             shr_cy,
  output logic [EXP_W-1:0] exp_out,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  state_t           state_q, state_d;
  logic [EXP_W-1:0] exp_a_q, exp_a_d;
  logic [EXP_W-1:0] exp_b_q, exp_b_d;
  logic [EXP_W-1:0] exp_r_q, exp_r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             shift_a_q, shift_a_d;
  logic             cy_q, cy_d;

  logic             ldm_a_q, ldm_a_d, shrm_a_q, shrm_a_d;
  logic             ldm_b_q, ldm_b_d, shrm_b_q, shrm_b_d;
  logic             ldm_r_q, ldm_r_d, shrm_r_q, shrm_r_d;
  logic             shlm_r_q, shlm_r_d, shr_cy_q, shr_cy_d;
  logic [EXP_W-1:0] exp_out_q, exp_out_d;
  logic             busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;

  logic [CNT_W-1:0] diff_sat;
  logic             a_lt_b;
  logic [EXP_W-1:0] exp_max;

  fpadd_exp_unit u_exp_unit (
    .exp_a    (exp_a_q),
    .exp_b    (exp_b_q),
    .diff_sat (diff_sat),
    .a_lt_b   (a_lt_b),
    .exp_max  (exp_max)
  );

  // Outputs are decided with the transition so they line up with the state they belong to
  always_comb begin
    state_d   = state_q;
    exp_a_d   = exp_a_q;
    exp_b_d   = exp_b_q;
    exp_r_d   = exp_r_q;
    cnt_d     = cnt_q;
    shift_a_d = shift_a_q;
    cy_d      = cy_q;
    ldm_a_d   = 1'b0;
    shrm_a_d  = 1'b0;
    ldm_b_d   = 1'b0;
    shrm_b_d  = 1'b0;
    ldm_r_d   = 1'b0;
    shrm_r_d  = 1'b0;
    shlm_r_d  = 1'b0;
    shr_cy_d  = 1'b0;
    ovf_d     = 1'b0;
    done_d    = 1'b0;
    exp_out_d = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          exp_a_d = exp_a;
          exp_b_d = exp_b;
          ldm_a_d = 1'b1;
          ldm_b_d = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        exp_r_d   = exp_max;
        cnt_d     = diff_sat;
        shift_a_d = a_lt_b;
        if (diff_sat != '0) begin
          shrm_a_d = a_lt_b;
          shrm_b_d = ~a_lt_b;
          state_d  = S_ALIGN;
        end else begin
          ldm_r_d = 1'b1;
          state_d = S_ADD;
        end
      end
      S_ALIGN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          ldm_r_d = 1'b1;
          state_d = S_ADD;
        end else begin
          shrm_a_d = shift_a_q;
          shrm_b_d = ~shift_a_q;
        end
      end
      S_ADD: begin
        cy_d    = add_cy;
        state_d = S_NORM;
      end
      S_NORM: begin
        if (cy_q) begin
          shrm_r_d = 1'b1;
          shr_cy_d = 1'b1;
          cy_d     = 1'b0;
          if (exp_r_q >= EXP_OVF_LIM) begin
            ovf_d   = 1'b1;
            exp_r_d = EXP_MAX;
          end else begin
            exp_r_d = exp_r_q + EXP_W'(1);
          end
          state_d = S_DONE;
        end else if (res_zero) begin
          exp_r_d = '0;
          state_d = S_DONE;
        end else if (!res_msb) begin
          if (exp_r_q > EXP_W'(1)) begin
            shlm_r_d = 1'b1;
            exp_r_d  = exp_r_q - EXP_W'(1);
          end else begin
            exp_r_d = '0;
            state_d = S_DONE;
          end
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_DONE) begin
      done_d    = 1'b1;
      exp_out_d = exp_r_d;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      exp_a_q   <= '0;
      exp_b_q   <= '0;
      exp_r_q   <= '0;
      cnt_q     <= '0;
      shift_a_q <= 1'b0;
      cy_q      <= 1'b0;
      ldm_a_q   <= 1'b0;
      shrm_a_q  <= 1'b0;
      ldm_b_q   <= 1'b0;
      shrm_b_q  <= 1'b0;
      ldm_r_q   <= 1'b0;
      shrm_r_q  <= 1'b0;
      shlm_r_q  <= 1'b0;
      shr_cy_q  <= 1'b0;
      exp_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_a_q   <= exp_a_d;
      exp_b_q   <= exp_b_d;
      exp_r_q   <= exp_r_d;
      cnt_q     <= cnt_d;
      shift_a_q <= shift_a_d;
      cy_q      <= cy_d;
      ldm_a_q   <= ldm_a_d;
      shrm_a_q  <= shrm_a_d;
      ldm_b_q   <= ldm_b_d;
      shrm_b_q  <= shrm_b_d;
      ldm_r_q   <= ldm_r_d;
      shrm_r_q  <= shrm_r_d;
      shlm_r_q  <= shlm_r_d;
      shr_cy_q  <= shr_cy_d;
      exp_out_q <= exp_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ldm_a   = ldm_a_q;
  assign shrm_a  = shrm_a_q;
  assign ldm_b   = ldm_b_q;
  assign shrm_b  = shrm_b_q;
  assign ldm_r   = ldm_r_q;
  assign shrm_r  = shrm_r_q;
  assign shlm_r  = shlm_r_q;
  assign shr_cy  = shr_cy_q;
  assign exp_out = exp_out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_fpadd_seq_ctrl.sv
// Directed-vector bench for fpadd_seq_ctrl with hand-computed latencies and exponents.
module tb_fpadd_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, add_cy, res_msb, res_zero;
  logic [7:0] exp_a, exp_b;
  logic       ldm_a, shrm_a, ldm_b, shrm_b, ldm_r, shrm_r, shlm_r, shr_cy;
  logic [7:0] exp_out;
  logic       busy, done, ovf;

  fpadd_seq_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .exp_a    (exp_a),
    .exp_b    (exp_b),
    .add_cy   (add_cy),
    .res_msb  (res_msb),
    .res_zero (res_zero),
    .ldm_a    (ldm_a),
    .shrm_a   (shrm_a),
    .ldm_b    (ldm_b),
    .shrm_b   (shrm_b),
    .ldm_r    (ldm_r),
    .shrm_r   (shrm_r),
    .shlm_r   (shlm_r),
    .shr_cy   (shr_cy),
    .exp_out  (exp_out),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int         r_lat, r_na, r_nb, r_nl, r_nr, r_ncy, r_bad;
  int         r_fa, r_la, r_fb, r_lb;
  logic [7:0] r_exp;
  logic       r_ovf;

  // One operation; R's msb reads 0 for the first nlow NORM cycles, then 1
  task automatic run_op(input logic [7:0] ea, input logic [7:0] eb, input logic cy,
                        input logic zero, input int nlow);
    int norm_idx;
    bit in_norm;
    r_lat = -1; r_na = 0; r_nb = 0; r_nl = 0; r_nr = 0; r_ncy = 0; r_bad = 0;
    r_fa = 0; r_la = -1; r_fb = 0; r_lb = -1; r_exp = '0; r_ovf = 1'b0;
    norm_idx = 0; in_norm = 0;
    exp_a = ea; exp_b = eb; add_cy = cy; res_zero = zero; res_msb = 1'b1; start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (in_norm) begin
        norm_idx++;
        res_msb = (norm_idx > nlow);
      end
      if (ldm_r) begin
        in_norm  = 1;
        norm_idx = 0;
      end
      if (shrm_a) begin r_na++; if (r_la < 0) r_fa = c; r_la = c; end
      if (shrm_b) begin r_nb++; if (r_lb < 0) r_fb = c; r_lb = c; end
      if (shlm_r) r_nl++;
      if (shrm_r) r_nr++;
      if (shr_cy) r_ncy++;
      if (shr_cy && !shrm_r) r_bad++;
      if (int'(ldm_a) + int'(shrm_a) > 1) r_bad++;
      if (int'(ldm_b) + int'(shrm_b) > 1) r_bad++;
      if (int'(ldm_r) + int'(shrm_r) + int'(shlm_r) > 1) r_bad++;
      if (!busy) r_bad++;
      if (done) begin
        r_lat = c;
        r_exp = exp_out;
        r_ovf = ovf;
        break;
      end
    end
    @(posedge clk); #1;
    check_eq("done_drop", 32'(done), 32'd0);
    check_eq("busy_drop", 32'(busy), 32'd0);
  endtask

  task automatic check_op(input string tag, input int lat, input logic [7:0] ex,
                          input logic ov, input int na, input int nb, input int nl, input int nr);
    check_eq({tag, "_lat"}, 32'(r_lat), 32'(lat));
    check_eq({tag, "_exp"}, 32'(r_exp), 32'(ex));
    check_eq({tag, "_ovf"}, 32'(r_ovf), 32'(ov));
    check_eq({tag, "_shrm_a"}, 32'(r_na), 32'(na));
    check_eq({tag, "_shrm_b"}, 32'(r_nb), 32'(nb));
    check_eq({tag, "_shlm_r"}, 32'(r_nl), 32'(nl));
    check_eq({tag, "_shrm_r"}, 32'(r_nr), 32'(nr));
    check_eq({tag, "_shr_cy"}, 32'(r_ncy), 32'(nr));
    check_eq({tag, "_ctl"}, 32'(r_bad), 32'd0);
  endtask

  int dones, first_done;

  initial begin
    reset = 1'b0; start = 1'b0; exp_a = '0; exp_b = '0;
    add_cy = 1'b0; res_msb = 1'b1; res_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ctl", 32'({ldm_a, shrm_a, ldm_b, shrm_b, ldm_r, shrm_r, shlm_r, shr_cy,
                             busy, done, ovf}), 32'd0);
    check_eq("rst_exp", 32'(exp_out), 32'd0);
    @(negedge clk); reset = 1'b1;

    run_op(8'd127, 8'd127, 1'b0, 1'b0, 0); check_op("eq", 4, 8'd127, 1'b0, 0, 0, 0, 0);
    run_op(8'd130, 8'd127, 1'b0, 1'b0, 0); check_op("d3", 7, 8'd130, 1'b0, 0, 3, 0, 0);
    check_eq("d3_run", 32'(r_lb - r_fb + 1), 32'd3);
    run_op(8'd100, 8'd160, 1'b0, 1'b0, 0); check_op("d60", 29, 8'd160, 1'b0, 25, 0, 0, 0);
    check_eq("d60_run", 32'(r_la - r_fa + 1), 32'd25);
    run_op(8'd151, 8'd127, 1'b0, 1'b0, 0); check_op("d24", 28, 8'd151, 1'b0, 0, 24, 0, 0);
    run_op(8'd127, 8'd153, 1'b0, 1'b0, 0); check_op("d26", 29, 8'd153, 1'b0, 25, 0, 0, 0);
    run_op(8'd127, 8'd127, 1'b1, 1'b0, 0); check_op("cy", 4, 8'd128, 1'b0, 0, 0, 0, 1);
    run_op(8'd254, 8'd254, 1'b1, 1'b0, 0); check_op("ovf", 4, 8'd255, 1'b1, 0, 0, 0, 1);
    run_op(8'd127, 8'd127, 1'b0, 1'b0, 3); check_op("nrm3", 7, 8'd124, 1'b0, 0, 0, 3, 0);
    run_op(8'd127, 8'd127, 1'b0, 1'b1, 0); check_op("zero", 4, 8'd0, 1'b0, 0, 0, 0, 0);
    run_op(8'd1, 8'd1, 1'b0, 1'b0, 5);     check_op("flush1", 4, 8'd0, 1'b0, 0, 0, 0, 0);
    run_op(8'd2, 8'd2, 1'b0, 1'b0, 5);     check_op("flush2", 5, 8'd0, 1'b0, 0, 0, 1, 0);

    // Reset asserted in the middle of alignment
    exp_a = 8'd100; exp_b = 8'd160; add_cy = 1'b0; res_zero = 1'b0; res_msb = 1'b1;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check_eq("mid_align", 32'(shrm_a), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("async_ctl", 32'({ldm_a, shrm_a, ldm_b, shrm_b, ldm_r, shrm_r, shlm_r, shr_cy,
                               busy, done, ovf}), 32'd0);
    check_eq("async_exp", 32'(exp_out), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    check_eq("abandoned", 32'(dones), 32'd0);

    // start while busy and in the DONE cycle must be ignored
    exp_a = 8'd130; exp_b = 8'd127; start = 1'b1;
    dones = 0; first_done = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 2) begin start = 1'b1; exp_a = 8'd127; exp_b = 8'd127; end
      if (first_done >= 0 && c == first_done + 1) check_eq("dn_ign_busy1", 32'(busy), 32'd0);
      if (first_done >= 0 && c == first_done + 2) check_eq("dn_ign_busy2", 32'(busy), 32'd0);
      if (done) begin
        dones++;
        if (first_done < 0) begin
          first_done = c;
          check_eq("busy_ign_exp", 32'(exp_out), 32'd130);
          start = 1'b1;
        end
      end
    end
    check_eq("busy_ign_done", 32'(dones), 32'd1);
    check_eq("busy_ign_lat", 32'(first_done), 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
